// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back sequencer: wb_mode encodings,
// the sequencer FSM states and default widths.
package rf_wb_pkg;

  localparam int RF_REG_W  = 4;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    MODE_DISCARD = 2'b00,
    MODE_LO      = 2'b01,
    MODE_HI      = 2'b10,
    MODE_FULL    = 2'b11
  } wb_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_H,
    WR_H,
    RD_L,
    WR_L
  } wb_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back entries; also exposes every slot's valid/reg/mode
// so the sequencer can build its pending-register mask.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = RF_REG_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [REG_W-1:0]            push_reg_i,
  input  logic [DATA_W-1:0]           push_data_i,
  input  logic [1:0]                  push_mode_i,
  input  logic                        pop_i,
  output logic [REG_W-1:0]            head_reg_o,
  output logic [DATA_W-1:0]           head_data_o,
  output logic [1:0]                  head_mode_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [DEPTH-1:0]            entry_valid_o,
  output logic [DEPTH-1:0][REG_W-1:0] entry_reg_o,
  output logic [DEPTH-1:0][1:0]       entry_mode_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [1:0]        mode_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    valid_d = valid_q;
    if (do_push) valid_d[wr_ptr_q] = 1'b1;
    if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; only the valid bits and pointers qualify it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      reg_mem[wr_ptr_q]  <= push_reg_i;
      data_mem[wr_ptr_q] <= push_data_i;
      mode_mem[wr_ptr_q] <= push_mode_i;
    end
  end

  assign head_reg_o    = reg_mem[rd_ptr_q];
  assign head_data_o   = data_mem[rd_ptr_q];
  assign head_mode_o   = mode_mem[rd_ptr_q];
  assign entry_valid_o = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_reg_o[i]  = reg_mem[i];
      entry_mode_o[i] = mode_mem[i];
    end
  end

endmodule

// File: rtl/rf_wb_seq.sv
// Write-back sequencer: buffers execute results and turns each into the register
// file's read-then-write half-word protocol, tracking registers with writes in flight.
module rf_wb_seq
  import rf_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = RF_REG_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [REG_W-1:0]      wb_reg_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic [1:0]            wb_mode_i,
  output logic                  rf_we_o,
  output logic                  rf_hl_o,
  output logic [REG_W-1:0]      rf_write_reg_o,
  output logic [DATA_W-1:0]     rf_data_o,
  output logic                  rf_read_slot_o,
  output logic                  pending_o,
  output logic [(1<<REG_W)-1:0] pend_mask_o
);

  wb_state_e         state_q, state_d;
  logic [REG_W-1:0]  cur_reg_q, cur_reg_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic [1:0]        cur_mode_q, cur_mode_d;
  logic              pop, decide;

  logic [REG_W-1:0]            head_reg;
  logic [DATA_W-1:0]           head_data;
  logic [1:0]                  head_mode;
  logic                        fifo_full, fifo_empty;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_reg;
  logic [DEPTH-1:0][1:0]       entry_mode;

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (wb_valid_i),
    .push_reg_i   (wb_reg_i),
    .push_data_i  (wb_data_i),
    .push_mode_i  (wb_mode_i),
    .pop_i        (pop),
    .head_reg_o   (head_reg),
    .head_data_o  (head_data),
    .head_mode_o  (head_mode),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .entry_valid_o(entry_valid),
    .entry_reg_o  (entry_reg),
    .entry_mode_o (entry_mode)
  );

  // The pop decision is shared by IDLE and the last write of an entry, so the
  // next entry's read cycle follows its predecessor's write with no bubble.
  always_comb begin
    state_d    = state_q;
    cur_reg_d  = cur_reg_q;
    cur_data_d = cur_data_q;
    cur_mode_d = cur_mode_q;
    pop        = 1'b0;
    decide     = 1'b0;
    case (state_q)
      IDLE:    decide = 1'b1;
      RD_H:    state_d = WR_H;
      WR_H:    if (cur_mode_q == MODE_FULL) state_d = RD_L;
               else decide = 1'b1;
      RD_L:    state_d = WR_L;
      WR_L:    decide = 1'b1;
      default: state_d = IDLE;
    endcase
    if (decide) begin
      state_d = IDLE;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_mode != MODE_DISCARD) begin
          cur_reg_d  = head_reg;
          cur_data_d = head_data;
          cur_mode_d = head_mode;
          state_d    = (head_mode == MODE_LO) ? RD_L : RD_H;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_reg_q  <= '0;
      cur_data_q <= '0;
      cur_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_reg_q  <= cur_reg_d;
      cur_data_q <= cur_data_d;
      cur_mode_q <= cur_mode_d;
    end
  end

  assign rf_we_o        = (state_q == WR_H) || (state_q == WR_L);
  assign rf_hl_o        = (state_q == WR_H);
  assign rf_write_reg_o = cur_reg_q;
  assign rf_data_o      = cur_data_q;
  assign rf_read_slot_o = !rf_we_o;
  assign wb_ready_o     = !fifo_full;
  assign pending_o      = !fifo_empty || (state_q != IDLE);

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_mode[i] != MODE_DISCARD)) pend_mask_o[entry_reg[i]] = 1'b1;
    end
    if (state_q != IDLE) pend_mask_o[cur_reg_q] = 1'b1;
  end

endmodule

// File: tb/tb_rf_wb_seq.sv
// Directed bench for rf_wb_seq with a behavioural half-word-merging register file.
module tb_rf_wb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  wb_mode;
  logic        rf_we, rf_hl, rf_read_slot, pending;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_data;
  logic [15:0] pend_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_seq #(.DEPTH(4), .REG_W(4), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wb_valid_i    (wb_valid),
    .wb_ready_o    (wb_ready),
    .wb_reg_i      (wb_reg),
    .wb_data_i     (wb_data),
    .wb_mode_i     (wb_mode),
    .rf_we_o       (rf_we),
    .rf_hl_o       (rf_hl),
    .rf_write_reg_o(rf_write_reg),
    .rf_data_o     (rf_data),
    .rf_read_slot_o(rf_read_slot),
    .pending_o     (pending),
    .pend_mask_o   (pend_mask)
  );

  // Register file model: a read cycle latches the addressed register, a write
  // cycle merges the selected half of rf_data with that latched value.
  logic [31:0] rf [16];
  logic [31:0] rd_latch;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  int          wr_log[$];

  always @(posedge clk) begin
    if (pre_en) rf[pre_idx] <= pre_val;
    else if (rf_we) begin
      rf[rf_write_reg] <= rf_hl ? {rf_data[31:16], rd_latch[15:0]} : {rd_latch[31:16], rf_data[15:0]};
      wr_log.push_back(int'(rf_write_reg));
    end else rd_latch <= rf[rf_write_reg];
  end

  logic prev_we = 1'b0;
  int   we_viol = 0;
  always @(negedge clk) begin
    if (rf_we && prev_we) we_viol++;
    prev_we = rf_we;
  end

  logic [3:0]  bp_reg  [6] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd12};
  logic [1:0]  bp_mode [6] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
  logic [31:0] bp_data [6] = '{32'h0101A1A1, 32'h0202B2B2, 32'h0404C4C4,
                               32'h0606D6D6, 32'h0808E8E8, 32'h0C0CF0F0};
  int          bp_order[10] = '{1, 1, 2, 2, 6, 6, 8, 8, 12, 12};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    step();
    pre_en  = 1'b0;
  endtask

  task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic [1:0] m);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    wb_mode  = m;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0; wb_mode = '0;
    repeat (3) step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_we: got %b want 0", rf_we); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_hold_ready: got %b want 1", wb_ready); end
    rst_n = 1'b1;
    step();
    checks++; if ({rf_we, rf_hl, rf_write_reg, rf_data} !== 38'h0) begin errors++; $display("[TB] FAIL reset_rf_outputs: we=%b hl=%b reg=%h data=%h want all 0", rf_we, rf_hl, rf_write_reg, rf_data); end
    checks++; if (rf_read_slot !== 1'b1) begin errors++; $display("[TB] FAIL reset_read_slot: got %b want 1", rf_read_slot); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", wb_ready); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b want 0", pending); end
    checks++; if (pend_mask !== 16'h0) begin errors++; $display("[TB] FAIL reset_pend_mask: got %h want 0000", pend_mask); end
    n = 0;
    repeat (10) begin step(); if (rf_we !== 1'b0) n++; end
    checks++; if (n != 0) begin errors++; $display("[TB] FAIL reset_idle_we: got %0d pulses want 0", n); end
  endtask

  task automatic test_low_half();
    preload(4'd3, 32'hAAAA5555);
    drive(4'd3, 32'h1234BEEF, 2'b01);
    step();
    wb_valid = 1'b0;
    checks++; if (pend_mask !== 16'h0008 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL lo_accept: mask=%h we=%b want 0008/0", pend_mask, rf_we); end
    step();
    checks++; if (rf_we !== 1'b0 || rf_write_reg !== 4'd3 || pend_mask !== 16'h0008) begin errors++; $display("[TB] FAIL lo_read: we=%b reg=%h mask=%h want 0/3/0008", rf_we, rf_write_reg, pend_mask); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_hl !== 1'b0 || rf_data !== 32'h1234BEEF || rf_read_slot !== 1'b0) begin errors++; $display("[TB] FAIL lo_write: we=%b hl=%b data=%h slot=%b want 1/0/1234beef/0", rf_we, rf_hl, rf_data, rf_read_slot); end
    checks++; if (pend_mask !== 16'h0008) begin errors++; $display("[TB] FAIL lo_write_mask: got %h want 0008", pend_mask); end
    step();
    checks++; if (rf[3] !== 32'hAAAABEEF) begin errors++; $display("[TB] FAIL lo_result: got %h want aaaabeef", rf[3]); end
    checks++; if (rf_we !== 1'b0 || pend_mask !== 16'h0 || pending !== 1'b0) begin errors++; $display("[TB] FAIL lo_done: we=%b mask=%h pend=%b want 0/0000/0", rf_we, pend_mask, pending); end
  endtask

  task automatic test_full_word();
    preload(4'd7, 32'h0);
    drive(4'd7, 32'hDEADBEEF, 2'b11);
    step();
    wb_valid = 1'b0;
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL full_rd_h: we=%b want 0", rf_we); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_hl !== 1'b1) begin errors++; $display("[TB] FAIL full_wr_h: we=%b hl=%b want 1/1", rf_we, rf_hl); end
    step();
    checks++; if (rf_we !== 1'b0 || rf[7] !== 32'hDEAD0000) begin errors++; $display("[TB] FAIL full_rd_l: we=%b reg7=%h want 0/dead0000", rf_we, rf[7]); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_hl !== 1'b0) begin errors++; $display("[TB] FAIL full_wr_l: we=%b hl=%b want 1/0", rf_we, rf_hl); end
    step();
    checks++; if (rf[7] !== 32'hDEADBEEF || pending !== 1'b0) begin errors++; $display("[TB] FAIL full_result: reg7=%h pend=%b want deadbeef/0", rf[7], pending); end
  endtask

  task automatic test_back_to_back();
    int cyc, log0;
    preload(4'd5, 32'h0);
    log0 = wr_log.size();
    drive(4'd5, 32'h11110000, 2'b10);
    step();
    drive(4'd5, 32'h00002222, 2'b01);
    step();
    wb_valid = 1'b0;
    cyc = 0;
    while (pending && cyc < 30) begin step(); cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL b2b_drain_cycles: got %0d want 4", cyc); end
    checks++; if (rf[5] !== 32'h11112222) begin errors++; $display("[TB] FAIL b2b_result: got %h want 11112222", rf[5]); end
    checks++; if (wr_log.size() - log0 != 2) begin errors++; $display("[TB] FAIL b2b_writes: got %0d want 2", wr_log.size() - log0); end
  endtask

  task automatic test_backpressure();
    int idx, cyc, log0;
    logic rdy, saw_full, pm4;
    preload(4'd4, 32'h44444444);
    log0 = wr_log.size();
    idx = 0; cyc = 0; saw_full = 1'b0; pm4 = 1'b0;
    while (idx < 6 && cyc < 50) begin
      drive(bp_reg[idx], bp_data[idx], bp_mode[idx]);
      rdy = wb_ready;
      if (!rdy) saw_full = 1'b1;
      if (pend_mask[4]) pm4 = 1'b1;
      step();
      cyc++;
      if (rdy) idx++;
    end
    wb_valid = 1'b0;
    checks++; if (idx != 6) begin errors++; $display("[TB] FAIL bp_push_timeout: pushed %0d want 6", idx); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_low: saw %b want 1", saw_full); end
    cyc = 0;
    while (pending && cyc < 100) begin
      if (pend_mask[4]) pm4 = 1'b1;
      step();
      cyc++;
    end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_timeout: pending=%b want 0", pending); end
    checks++; if (pm4 !== 1'b0) begin errors++; $display("[TB] FAIL bp_discard_mask: bit4 seen=%b want 0", pm4); end
    checks++; if (wr_log.size() - log0 != 10) begin errors++; $display("[TB] FAIL bp_write_count: got %0d want 10", wr_log.size() - log0); end
    for (int k = 0; k < 10; k++) begin
      if (log0 + k < wr_log.size()) begin
        checks++; if (wr_log[log0 + k] != bp_order[k]) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %0d want %0d", k, wr_log[log0 + k], bp_order[k]); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rf[bp_reg[k]] !== ((bp_mode[k] == 2'b00) ? 32'h44444444 : bp_data[k])) begin
        errors++; $display("[TB] FAIL bp_value reg%0d: got %h want %h", bp_reg[k], rf[bp_reg[k]], (bp_mode[k] == 2'b00) ? 32'h44444444 : bp_data[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    preload(4'd9, 32'h0);
    preload(4'd10, 32'h10101010);
    drive(4'd9, 32'hCAFEF00D, 2'b11);
    step();
    drive(4'd10, 32'h12345678, 2'b11);
    step();
    wb_valid = 1'b0;
    step();
    step();
    checks++; if (rf[9] !== 32'hCAFE0000) begin errors++; $display("[TB] FAIL rst_high_written: got %h want cafe0000", rf[9]); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_hl !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_wr_l: we=%b hl=%b want 1/0", rf_we, rf_hl); end
    #2;
    rst_n = 1'b0;
    n0 = wr_log.size();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_we: got %b want 0", rf_we); end
    checks++; if (pending !== 1'b0 || pend_mask !== 16'h0) begin errors++; $display("[TB] FAIL rst_async_pending: pend=%b mask=%h want 0/0000", pending, pend_mask); end
    step();
    rst_n = 1'b1;
    repeat (12) step();
    checks++; if (wr_log.size() != n0) begin errors++; $display("[TB] FAIL rst_no_more_writes: got %0d extra want 0", wr_log.size() - n0); end
    checks++; if (rf[9] !== 32'hCAFE0000 || rf[10] !== 32'h10101010) begin errors++; $display("[TB] FAIL rst_final_values: reg9=%h reg10=%h want cafe0000/10101010", rf[9], rf[10]); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_pending: got %b want 0", pending); end
  endtask

  task automatic test_we_spacing();
    checks++; if (we_viol != 0) begin errors++; $display("[TB] FAIL we_spacing: got %0d consecutive pulses want 0", we_viol); end
  endtask

  initial begin
    test_reset();
    test_low_half();
    test_full_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_we_spacing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
